// File: rtl/main_decoder_pkg.sv
// Shared opcode/ALUop constants and the packed control word for the main decoder.
// The decode function is the single source of truth for the opcode-to-control mapping.
package main_decoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_IDLE;
    case (op)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        c.aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.memtoreg = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.branch   = 1'b1;
        c.aluop    = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_J: begin
        c.jump     = 1'b1;
      end
      // Unknown opcodes leave every state-changing control low.
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Main control decoder: opcode to datapath control word, with an optional
// asynchronously-reset output register stage selected by REGISTERED.
module main_decoder
  import main_decoder_pkg::*;
#(
  parameter int REGISTERED = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrc,
  output logic       branch,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       jump,
  output logic [1:0] ALUop,
  output logic       illegal
);

  ctrl_t ctrl_p0;
  ctrl_t ctrl_p1;

  // stage p0: combinational decode
  always_comb begin
    ctrl_p0 = decode(op);
  end

  // stage p1: optional output register
  generate
    if (REGISTERED != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrl_p1 <= CTRL_IDLE;
        end else begin
          ctrl_p1 <= ctrl_p0;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign ctrl_p1 = ctrl_p0;
    end
  endgenerate

  assign regwrite = ctrl_p1.regwrite;
  assign regdst   = ctrl_p1.regdst;
  assign alusrc   = ctrl_p1.alusrc;
  assign branch   = ctrl_p1.branch;
  assign memwrite = ctrl_p1.memwrite;
  assign memtoreg = ctrl_p1.memtoreg;
  assign jump     = ctrl_p1.jump;
  assign ALUop    = ctrl_p1.aluop;
  assign illegal  = ctrl_p1.illegal;

endmodule

// File: tb/tb_main_decoder.sv
// Scoreboard bench for main_decoder: a registered build checked through an
// expectation queue one cycle later, and a combinational build checked in place.
module tb_main_decoder;

  // Control word order: regwrite regdst alusrc branch memwrite memtoreg jump ALUop[1:0] illegal
  localparam logic [9:0] W_RTYPE = 10'b1100000_10_0;
  localparam logic [9:0] W_LW    = 10'b1010010_00_0;
  localparam logic [9:0] W_SW    = 10'b0010100_00_0;
  localparam logic [9:0] W_BEQ   = 10'b0001000_01_0;
  localparam logic [9:0] W_ADDI  = 10'b1010000_00_0;
  localparam logic [9:0] W_J     = 10'b0000001_00_0;
  localparam logic [9:0] W_ILL   = 10'b0000000_00_1;
  localparam logic [9:0] W_ZERO  = 10'b0000000_00_0;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [9:0] exp;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;

  logic       r_regwrite, r_regdst, r_alusrc, r_branch, r_memwrite, r_memtoreg, r_jump, r_illegal;
  logic [1:0] r_aluop;
  logic       c_regwrite, c_regdst, c_alusrc, c_branch, c_memwrite, c_memtoreg, c_jump, c_illegal;
  logic [1:0] c_aluop;

  sb_t sbq[$];
  int  n_vec;
  int  n_err;
  int  n_ill;

  main_decoder #(.REGISTERED(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op),
    .regwrite(r_regwrite), .regdst(r_regdst), .alusrc(r_alusrc), .branch(r_branch),
    .memwrite(r_memwrite), .memtoreg(r_memtoreg), .jump(r_jump), .ALUop(r_aluop),
    .illegal(r_illegal)
  );

  main_decoder #(.REGISTERED(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .op(op),
    .regwrite(c_regwrite), .regdst(c_regdst), .alusrc(c_alusrc), .branch(c_branch),
    .memwrite(c_memwrite), .memtoreg(c_memtoreg), .jump(c_jump), .ALUop(c_aluop),
    .illegal(c_illegal)
  );

  wire [9:0] r_word = {r_regwrite, r_regdst, r_alusrc, r_branch, r_memwrite,
                       r_memtoreg, r_jump, r_aluop, r_illegal};
  wire [9:0] c_word = {c_regwrite, c_regdst, c_alusrc, c_branch, c_memwrite,
                       c_memtoreg, c_jump, c_aluop, c_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [5:0] o);
    case (o)
      6'b000000: return W_RTYPE;
      6'b100011: return W_LW;
      6'b101011: return W_SW;
      6'b000100: return W_BEQ;
      6'b001000: return W_ADDI;
      6'b000010: return W_J;
      default:   return W_ILL;
    endcase
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_inv(input string name, input logic [9:0] w);
    n_vec++;
    if ((^w === 1'bx) || (w[9] && w[5]) || (w[6] && w[3])) begin
      n_err++;
      $display("FAIL %s: word %b has X or violates regwrite/memwrite, branch/jump exclusion", name, w);
    end
  endtask

  // Drive op at the falling edge, queue the registered expectation, check the comb build now.
  task automatic apply(input string name, input logic [5:0] o, input logic [9:0] exp);
    sb_t e;
    @(negedge clk);
    op = o;
    e.name = name;
    e.op   = o;
    e.exp  = exp;
    sbq.push_back(e);
    #1;
    check({name, "_comb"}, c_word, exp);
  endtask

  // Monitor: every cycle the registered build presents the decode of the op queued before the edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.name, r_word, e.exp);
        check_inv({e.name, "_inv"}, r_word);
      end
    end
  end

  initial begin
    int drain;
    n_vec = 0;
    n_err = 0;
    n_ill = 0;
    rst_n = 1'b0;
    op    = 6'b000000;

    // Reset held with R-type on op: everything low.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", r_word, W_ZERO);

    // Release between edges; first edge loads R-type decode.
    @(negedge clk);
    rst_n = 1'b1;
    begin
      sb_t e;
      e.name = "post_reset_rtype";
      e.op   = 6'b000000;
      e.exp  = W_RTYPE;
      sbq.push_back(e);
    end

    // Legal opcode sweep, one per cycle.
    apply("rtype", 6'b000000, W_RTYPE);
    apply("lw",    6'b100011, W_LW);
    apply("sw",    6'b101011, W_SW);
    apply("beq",   6'b000100, W_BEQ);
    n_vec++;
    if (!(c_branch === 1'b1 && c_aluop === 2'b01)) begin
      n_err++;
      $display("FAIL beq_comb_same_step: branch=%b ALUop=%b expected branch=1 ALUop=01", c_branch, c_aluop);
    end
    apply("addi",  6'b001000, W_ADDI);
    apply("j",     6'b000010, W_J);
    apply("op_3f", 6'b111111, W_ILL);

    // Async reset mid-cycle with LW decoded: clears without an edge.
    apply("lw_pre_reset", 6'b100011, W_LW);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (r_regwrite !== 1'b0 || r_memtoreg !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_lw: regwrite=%b memtoreg=%b expected 0 0", r_regwrite, r_memtoreg);
    end
    check("async_reset_word", r_word, W_ZERO);
    @(posedge clk);
    #1;
    check("reset_discard", r_word, W_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      sb_t e;
      e.name = "post_reset_lw";
      e.op   = 6'b100011;
      e.exp  = W_LW;
      sbq.push_back(e);
    end

    // Exhaustive opcode walk.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] o;
      o = i[5:0];
      apply($sformatf("op_%02h", o), o, model(o));
      if (c_illegal === 1'b1) n_ill++;
    end
    n_vec++;
    if (n_ill != 58) begin
      n_err++;
      $display("FAIL illegal_count: got %0d expected 58", n_ill);
    end

    drain = 0;
    while (sbq.size() > 0 && drain < 5) begin
      @(posedge clk);
      #2;
      drain++;
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
